mc_control_unit: RTL and testbench

Multicycle MIPS main controller: a Moore/Mealy FSM that steps each instruction through IF, ID, EXE, MEM and WB. It drives the datapath strobes and multiplexer selects, including the 2-bit register-destination select consumed by the 5-bit 4-to-1 write-address mux. It reads opcode and funct from the externally held instruction register and the ALU zero flag. It also keeps a retired-instruction counter.

---
 rtl/mc_control_unit.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// -----------------------------------------------------------------------------
// mc_control_unit
//
// Main controller for a multicycle MIPS datapath. Each instruction is stepped
// through IF, ID, EXE, MEM and WB. The state is registered, while every strobe
// and select is decoded combinationally from the current state plus
// op/funct/zero. The datapath samples them at the next rising edge.
// A retired-instruction counter is also kept.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   op         in   instruction[31:26] from the instruction register
//   funct      in   instruction[5:0] from the instruction register
//   zero       in   ALU zero flag, meaningful in EXE
//   pcWrite    out  load PC
//   pcSrc      out  00 PC+4, 01 branch target, 10 jump target, 11 rs (jr)
//   irWrite    out  load IR from memory
//   memRead    out  data memory read
//   memWrite   out  data memory write
//   regWrite   out  register file write
//   regDst     out  write address: 00 rt, 01 rd, 10 r31 (11 never driven)
//   wbSrc      out  write data: 00 ALU result, 01 memory data, 10 PC (link)
//   aluSrcB    out  0 register B, 1 extended immediate
//   extZero    out  1 zero-extend immediate, 0 sign-extend
//   aluOp      out  00 add, 01 sub, 10 decode funct, 11 or
//   halted     out  FSM is parked in HALT
//   state      out  current state code, for debug
//   instrCount out  retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mc_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pcWrite,
  output logic [1:0]       pcSrc,
  output logic             irWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             regWrite,
  output logic [1:0]       regDst,
  output logic [1:0]       wbSrc,
  output logic             aluSrcB,
  output logic             extZero,
  output logic [1:0]       aluOp,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instrCount
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // Select encodings used below
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;
  localparam logic [1:0] RD_RT     = 2'b00;
  localparam logic [1:0] RD_RD     = 2'b01;
  localparam logic [1:0] RD_R31    = 2'b10;
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  state_t           stateReg;
  state_t           stateNext;
  logic [CNT_W-1:0] countReg;

  // Ungated decode results
  logic       pcWriteDec;
  logic [1:0] pcSrcDec;
  logic       irWriteDec;
  logic       memReadDec;
  logic       memWriteDec;
  logic       regWriteDec;
  logic [1:0] regDstDec;
  logic [1:0] wbSrcDec;
  logic       aluSrcBDec;
  logic       extZeroDec;
  logic [1:0] aluOpDec;
  logic       haltedDec;

  logic isRType;
  logic isJr;
  logic isLegal;

  assign isRType = (op == OP_R);
  assign isJr    = isRType && (funct == FN_JR);

  // Anything outside the supported opcode set is retired as a nop from ID.
  always_comb begin
    case (op)
      OP_R, OP_ADDI, OP_ORI, OP_LW, OP_SW,
      OP_BEQ, OP_J, OP_JAL, OP_HALT: isLegal = 1'b1;
      default:                       isLegal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext   = S_IF;
    pcWriteDec  = 1'b0;
    pcSrcDec    = PC_PLUS4;
    irWriteDec  = 1'b0;
    memReadDec  = 1'b0;
    memWriteDec = 1'b0;
    regWriteDec = 1'b0;
    regDstDec   = RD_RT;
    wbSrcDec    = WB_ALU;
    aluSrcBDec  = 1'b0;
    extZeroDec  = 1'b0;
    aluOpDec    = ALU_ADD;
    haltedDec   = 1'b0;

    case (stateReg)
      S_IF: begin
        irWriteDec = 1'b1;
        pcWriteDec = 1'b1;
        pcSrcDec   = PC_PLUS4;
        stateNext  = S_ID;
      end

      S_ID: begin
        case (op)
          OP_J: begin
            pcWriteDec = 1'b1;
            pcSrcDec   = PC_JUMP;
            stateNext  = S_IF;
          end
          OP_JAL: begin
            // PC was already advanced in IF, so the link value is PC+4.
            pcWriteDec  = 1'b1;
            pcSrcDec    = PC_JUMP;
            regWriteDec = 1'b1;
            regDstDec   = RD_R31;
            wbSrcDec    = WB_PC;
            stateNext   = S_IF;
          end
          OP_HALT: stateNext = S_HALT;
          default: stateNext = isLegal ? S_EXE : S_IF;
        endcase
      end

      S_EXE: begin
        case (op)
          OP_R: begin
            if (isJr) begin
              pcWriteDec = 1'b1;
              pcSrcDec   = PC_RS;
              stateNext  = S_IF;
            end else begin
              aluOpDec   = ALU_FUNCT;
              aluSrcBDec = 1'b0;
              stateNext  = S_WB;
            end
          end
          OP_ADDI: begin
            aluOpDec   = ALU_ADD;
            aluSrcBDec = 1'b1;
            stateNext  = S_WB;
          end
          OP_ORI: begin
            aluOpDec   = ALU_OR;
            aluSrcBDec = 1'b1;
            extZeroDec = 1'b1;
            stateNext  = S_WB;
          end
          OP_LW, OP_SW: begin
            aluOpDec   = ALU_ADD;
            aluSrcBDec = 1'b1;
            stateNext  = S_MEM;
          end
          OP_BEQ: begin
            // Branch is resolved from the compare done in this same cycle.
            aluOpDec   = ALU_SUB;
            aluSrcBDec = 1'b0;
            pcSrcDec   = PC_BRANCH;
            pcWriteDec = zero;
            stateNext  = S_IF;
          end
          default: stateNext = S_IF;
        endcase
      end

      S_MEM: begin
        if (op == OP_LW) begin
          memReadDec = 1'b1;
          stateNext  = S_WB;
        end else begin
          memWriteDec = (op == OP_SW);
          stateNext   = S_IF;
        end
      end

      S_WB: begin
        regWriteDec = 1'b1;
        regDstDec   = isRType ? RD_RD : RD_RT;
        wbSrcDec    = (op == OP_LW) ? WB_MEM : WB_ALU;
        stateNext   = S_IF;
      end

      S_HALT: begin
        haltedDec = 1'b1;
        stateNext = S_HALT;
      end

      default: stateNext = S_IF;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and retirement counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= S_IF;
      countReg <= '0;
    end else begin
      stateReg <= stateNext;
      // An instruction retires whenever control returns to IF from elsewhere.
      if ((stateReg != S_IF) && (stateNext == S_IF)) begin
        countReg <= countReg + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: forced to 0 while reset is held, so nothing fires between the
  // asynchronous reset edge and the next clock.
  // ---------------------------------------------------------------------------
  assign pcWrite    = rst_n & pcWriteDec;
  assign irWrite    = rst_n & irWriteDec;
  assign memRead    = rst_n & memReadDec;
  assign memWrite   = rst_n & memWriteDec;
  assign regWrite   = rst_n & regWriteDec;
  assign aluSrcB    = rst_n & aluSrcBDec;
  assign extZero    = rst_n & extZeroDec;
  assign halted     = rst_n & haltedDec;
  assign pcSrc      = rst_n ? pcSrcDec  : 2'b00;
  assign regDst     = rst_n ? regDstDec : 2'b00;
  assign wbSrc      = rst_n ? wbSrcDec  : 2'b00;
  assign aluOp      = rst_n ? aluOpDec  : 2'b00;
  assign state      = stateReg;
  assign instrCount = countReg;

endmodule

// File: tb/tb_mc_control_unit.sv
// -----------------------------------------------------------------------------
// tb_mc_control_unit
//
// Directed bench for mc_control_unit. Expected output words are queued as each
// step is driven and popped when the DUT outputs are sampled on the falling
// edge. A second instance with a 4-bit counter shares all inputs and is used
// to check counter wrap.
// -----------------------------------------------------------------------------
module tb_mc_control_unit;

  logic        clk;
  logic        rst_n;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;

  logic        pcWrite, irWrite, memRead, memWrite, regWrite;
  logic        aluSrcB, extZero, halted;
  logic [1:0]  pcSrc, regDst, wbSrc, aluOp;
  logic [2:0]  state;
  logic [31:0] instrCount;

  logic        wPcWrite, wIrWrite, wMemRead, wMemWrite, wRegWrite;
  logic        wAluSrcB, wExtZero, wHalted;
  logic [1:0]  wPcSrc, wRegDst, wWbSrc, wAluOp;
  logic [2:0]  wState;
  logic [3:0]  wInstrCount;

  mc_control_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .pcWrite(pcWrite), .pcSrc(pcSrc), .irWrite(irWrite), .memRead(memRead),
    .memWrite(memWrite), .regWrite(regWrite), .regDst(regDst), .wbSrc(wbSrc),
    .aluSrcB(aluSrcB), .extZero(extZero), .aluOp(aluOp), .halted(halted),
    .state(state), .instrCount(instrCount)
  );

  mc_control_unit #(.CNT_W(4)) dutWrap (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .pcWrite(wPcWrite), .pcSrc(wPcSrc), .irWrite(wIrWrite), .memRead(wMemRead),
    .memWrite(wMemWrite), .regWrite(wRegWrite), .regDst(wRegDst), .wbSrc(wWbSrc),
    .aluSrcB(wAluSrcB), .extZero(wExtZero), .aluOp(wAluOp), .halted(wHalted),
    .state(wState), .instrCount(wInstrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [18:0] vec;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cnt;

  // Output word: {pcWrite,pcSrc,irWrite,memRead,memWrite,regWrite,regDst,
  //               wbSrc,aluSrcB,extZero,aluOp,halted,state}
  function automatic logic [18:0] ev(input logic [2:0] st, input logic pw,
                                     input logic [1:0] ps, input logic iw,
                                     input logic mr, input logic mw,
                                     input logic rw, input logic [1:0] rd,
                                     input logic [1:0] wb, input logic asb,
                                     input logic ez, input logic [1:0] aop,
                                     input logic h);
    return {pw, ps, iw, mr, mw, rw, rd, wb, asb, ez, aop, h, st};
  endfunction

  logic [18:0] V_RST, V_IF, V_ID, V_EXE_R, V_WB_R, V_EXE_ADDR, V_MEM_LW;
  logic [18:0] V_WB_LW, V_MEM_SW, V_EXE_BEQ1, V_EXE_BEQ0, V_ID_JAL, V_ID_J;
  logic [18:0] V_EXE_JR, V_EXE_ORI, V_WB_I, V_HALT;

  task automatic expectOut(input string tag, input logic [18:0] v);
    exp_t e;
    e.tag = tag;
    e.vec = v;
    e.cnt = cnt;
    sbq.push_back(e);
  endtask

  task automatic checkOut();
    exp_t        e;
    logic [18:0] obs;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sbq.pop_front();
    obs = {pcWrite, pcSrc, irWrite, memRead, memWrite, regWrite, regDst,
           wbSrc, aluSrcB, extZero, aluOp, halted, state};
    assert (obs === e.vec) else begin
      errors++;
      $error("FAIL %s outputs observed=%h expected=%h", e.tag, obs, e.vec);
    end
    checks++;
    assert (instrCount === e.cnt) else begin
      errors++;
      $error("FAIL %s instrCount observed=%0d expected=%0d", e.tag, instrCount, e.cnt);
    end
    $display("step %-12s state=%0d outputs=%h instrCount=%0d", e.tag, state, obs, instrCount);
  endtask

  // One clock cycle: queue expectation, sample on falling edge, advance.
  task automatic step(input string tag, input logic [18:0] v);
    expectOut(tag, v);
    @(negedge clk);
    checkOut();
    @(posedge clk);
    #1;
  endtask

  task automatic setInstr(input logic [5:0] o, input logic [5:0] f, input logic z);
    op    = o;
    funct = f;
    zero  = z;
  endtask

  initial begin
    V_RST      = '0;
    V_IF       = ev(3'd0, 1, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    V_ID       = ev(3'd1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    V_EXE_R    = ev(3'd2, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b10, 0);
    V_WB_R     = ev(3'd4, 0, 2'b00, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0, 2'b00, 0);
    V_EXE_ADDR = ev(3'd2, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 0);
    V_MEM_LW   = ev(3'd3, 0, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    V_WB_LW    = ev(3'd4, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0, 2'b00, 0);
    V_MEM_SW   = ev(3'd3, 0, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    V_EXE_BEQ1 = ev(3'd2, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 0);
    V_EXE_BEQ0 = ev(3'd2, 0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 0);
    V_ID_JAL   = ev(3'd1, 1, 2'b10, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 2'b00, 0);
    V_ID_J     = ev(3'd1, 1, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    V_EXE_JR   = ev(3'd2, 1, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    V_EXE_ORI  = ev(3'd2, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 2'b11, 0);
    V_WB_I     = ev(3'd4, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    V_HALT     = ev(3'd5, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 1);

    cnt   = '0;
    rst_n = 1'b0;
    setInstr(6'b000000, 6'b100000, 1'b0);

    // Reset state, then release just after a rising edge
    step("reset", V_RST);
    rst_n = 1'b1;

    // R-type add: IF ID EXE WB
    step("add_if", V_IF);
    step("add_id", V_ID);
    step("add_exe", V_EXE_R);
    step("add_wb", V_WB_R);
    cnt++;

    // lw: 5 cycles
    setInstr(6'b100011, 6'b000000, 1'b0);
    step("lw_if", V_IF);
    step("lw_id", V_ID);
    step("lw_exe", V_EXE_ADDR);
    step("lw_mem", V_MEM_LW);
    step("lw_wb", V_WB_LW);
    cnt++;

    // sw: 4 cycles, never writes the register file
    setInstr(6'b101011, 6'b000000, 1'b0);
    step("sw_if", V_IF);
    step("sw_id", V_ID);
    step("sw_exe", V_EXE_ADDR);
    step("sw_mem", V_MEM_SW);
    cnt++;

    // beq taken then not taken
    setInstr(6'b000100, 6'b000000, 1'b1);
    step("beq1_if", V_IF);
    step("beq1_id", V_ID);
    step("beq1_exe", V_EXE_BEQ1);
    cnt++;
    setInstr(6'b000100, 6'b000000, 1'b0);
    step("beq0_if", V_IF);
    step("beq0_id", V_ID);
    step("beq0_exe", V_EXE_BEQ0);
    cnt++;

    // jal and j resolve in ID
    setInstr(6'b000011, 6'b000000, 1'b0);
    step("jal_if", V_IF);
    step("jal_id", V_ID_JAL);
    cnt++;
    setInstr(6'b000010, 6'b000000, 1'b0);
    step("j_if", V_IF);
    step("j_id", V_ID_J);
    cnt++;

    // jr resolves in EXE
    setInstr(6'b000000, 6'b001000, 1'b0);
    step("jr_if", V_IF);
    step("jr_id", V_ID);
    step("jr_exe", V_EXE_JR);
    cnt++;

    // addi and ori
    setInstr(6'b001000, 6'b000000, 1'b0);
    step("addi_if", V_IF);
    step("addi_id", V_ID);
    step("addi_exe", V_EXE_ADDR);
    step("addi_wb", V_WB_I);
    cnt++;
    setInstr(6'b001101, 6'b000000, 1'b0);
    step("ori_if", V_IF);
    step("ori_id", V_ID);
    step("ori_exe", V_EXE_ORI);
    step("ori_wb", V_WB_I);
    cnt++;

    // Illegal opcode retires as a 2-cycle nop
    setInstr(6'b111110, 6'b000000, 1'b0);
    step("ill_if", V_IF);
    step("ill_id", V_ID);
    cnt++;

    // Reset asserted in the middle of a lw MEM cycle
    setInstr(6'b100011, 6'b000000, 1'b0);
    step("lwr_if", V_IF);
    step("lwr_id", V_ID);
    step("lwr_exe", V_EXE_ADDR);
    expectOut("lwr_mem", V_MEM_LW);
    @(negedge clk);
    checkOut();
    #1 rst_n = 1'b0;
    cnt = '0;
    #1;
    expectOut("lwr_async", V_RST);
    checkOut();
    @(posedge clk);
    #1;
    step("lwr_hold", V_RST);
    rst_n = 1'b1;

    // halt: HALT after ID, then 20 quiet cycles with the counter frozen
    setInstr(6'b000000, 6'b100000, 1'b0);
    step("pre_if", V_IF);
    step("pre_id", V_ID);
    step("pre_exe", V_EXE_R);
    step("pre_wb", V_WB_R);
    cnt++;
    setInstr(6'b111111, 6'b000000, 1'b1);
    step("halt_if", V_IF);
    step("halt_id", V_ID);
    for (int i = 0; i < 20; i++) begin
      step("halt_wait", V_HALT);
    end

    // Leave HALT through reset, then retire 17 nops for the wrap check
    rst_n = 1'b0;
    cnt   = '0;
    step("halt_rst", V_RST);
    rst_n = 1'b1;
    setInstr(6'b111110, 6'b000000, 1'b0);
    for (int i = 0; i < 17; i++) begin
      step("nop_if", V_IF);
      step("nop_id", V_ID);
      cnt++;
    end
    step("wrap_if", V_IF);
    checks++;
    assert (wInstrCount === 4'd1) else begin
      errors++;
      $error("FAIL wrap instrCount observed=%0d expected=1", wInstrCount);
    end
    $display("step wrap         narrow instrCount=%0d", wInstrCount);

    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
